alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 16 +
 rtl/ct_mod_N.sv | 25 ++
 rtl/alarm_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and sizing helpers for the alarm controller.
// The numeric state values are externally visible on the state port.
package alarm_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRing    = 2'd1,
        StSnooze  = 2'd2,
        StLockout = 2'd3
    } alarm_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ct_mod_N.sv
// Modulo-N up counter with synchronous reset, synchronous clear and count enable.
module ct_mod_N #(
    parameter int unsigned N = 10,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ct_out
);

    logic [W-1:0] ct_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ct_q <= '0;
        end else if (en) begin
            ct_q <= (ct_q == W'(N - 1)) ? '0 : ct_q + W'(1);
        end
    end

    assign ct_out = ct_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: match detection, ring/snooze/lockout sequencing and buzzer.
// Timer is a ct_mod_N instance whose clear is driven by the state machine.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 120,
    parameter int unsigned SNOOZE_SEC = 540,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter logic [6:0]  DAY_MASK   = 7'b0111110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] tsec,
    input  logic [6:0] tmin,
    input  logic [6:0] thrs,
    input  logic [6:0] day,
    input  logic [6:0] amin,
    input  logic [6:0] ahrs,
    input  logic       alarmon,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzz,
    output logic [1:0] state,
    output logic [1:0] snz_cnt
);

    // One extra count of headroom: the FSM always leaves at max-1, so the counter never wraps.
    localparam int unsigned TmrMax = max_u(RING_SEC, SNOOZE_SEC);
    localparam int unsigned TmrN   = TmrMax + 1;
    localparam int unsigned TmrW   = $clog2(TmrN);

    alarm_state_e state_q, state_d;
    logic [1:0]   snz_q, snz_d;
    logic [TmrW-1:0] tmr;
    logic         tmr_clr;
    logic         day_armed;
    logic         match;
    logic         same_minute;

    assign day_armed   = (day < 7'd7) && DAY_MASK[day[2:0]];
    assign same_minute = (tmin == amin) && (thrs == ahrs);
    assign match       = alarmon && (tsec == 7'd0) && same_minute && day_armed;

    ct_mod_N #(
        .N (TmrN),
        .W (TmrW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (1'b1),
        .ct_out (tmr)
    );

    // Timer keeps counting only while the FSM stays in RING or SNOOZE.
    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        tmr_clr = 1'b1;
        if (!alarmon) begin
            state_d = StIdle;
            snz_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    snz_d = 2'd0;
                    if (match) begin
                        state_d = StRing;
                    end
                end
                StRing: begin
                    if (dismiss) begin
                        state_d = StLockout;
                    end else if (snooze && (snz_q < 2'(MAX_SNOOZE))) begin
                        state_d = StSnooze;
                        snz_d   = snz_q + 2'd1;
                    end else if (tmr == TmrW'(RING_SEC - 1)) begin
                        state_d = StLockout;
                    end else begin
                        tmr_clr = 1'b0;
                    end
                end
                StSnooze: begin
                    if (dismiss) begin
                        state_d = StLockout;
                    end else if (tmr == TmrW'(SNOOZE_SEC - 1)) begin
                        state_d = StRing;
                    end else begin
                        tmr_clr = 1'b0;
                    end
                end
                StLockout: begin
                    if (!same_minute) begin
                        state_d = StIdle;
                        snz_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    snz_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            snz_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            snz_q   <= snz_d;
        end
    end

    assign buzz    = (state_q == StRing);
    assign state   = state_q;
    assign snz_cnt = snz_q;

endmodule
